mag_cmp_seq: RTL
================

MAG_CMP_SEQ -- requirements
Module: mag_cmp_seq

Interface
REQ-001 Parameter WIDTH, default 8; operand width in bits; SHALL be even and >= 2.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a comparison; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A, unsigned; sampled with start.
REQ-006 b  input  WIDTH  operand B, unsigned; sampled with start.
REQ-007 busy  output  1  high while a comparison is in progress.
REQ-008 done  output  1  one-cycle pulse; result valid.
REQ-009 gt  output  1  registered result, A > B.
REQ-010 eq  output  1  registered result, A == B.
REQ-011 lt  output  1  registered result, A < B.

Function
REQ-012 The comparison SHALL be performed one 2-bit slice per clock, MSB slice first, by a single 2-bit comparator slice.
REQ-013 FSM states SHALL be IDLE, CMP, DONE.
REQ-014 IDLE: start=1 at an edge -> latch a, b into operand registers; slice index = WIDTH/2-1; clear gt/eq/lt; go to CMP.
REQ-015 IDLE: start=0 -> stay in IDLE, outputs hold.
REQ-016 CMP: each edge evaluates the indexed slice of the latched operands.
REQ-017 CMP: slice A > B -> gt=1, go to DONE (early termination).
REQ-018 CMP: slice A < B -> lt=1, go to DONE (early termination).
REQ-019 CMP: slices equal and index = 0 -> eq=1, go to DONE.
REQ-020 CMP: slices equal and index > 0 -> decrement index, stay in CMP.
REQ-021 DONE: done=1 for exactly this cycle; next edge goes to IDLE unconditionally.
REQ-022 busy SHALL be 1 only in CMP; done SHALL be 1 only in DONE; both combinational decodes of the state register.
REQ-023 start is ignored in CMP and DONE; no queuing.
REQ-024 Operand changes on a, b after acceptance SHALL NOT affect the result in progress.
REQ-025 Latency: with start sampled in cycle 0 and n slices examined (1 <= n <= WIDTH/2), done SHALL be high in cycle n+1.
REQ-026 gt, eq, lt SHALL be mutually exclusive; they hold their value from DONE until the next accepted start, which clears them.
REQ-027 Back-to-back: start held high continuously SHALL be accepted in the first IDLE cycle after each DONE.

Reset
REQ-028 rst=1 SHALL immediately force state IDLE, busy=0, done=0, gt=eq=lt=0, index=0, operand registers=0.
REQ-029 Reset asserted mid-comparison SHALL abort it with no done pulse; after release the block waits in IDLE for a new start.

Structure
REQ-030 A shared package cmp_seq_pkg SHALL hold the FSM state encoding (IDLE, CMP, DONE) and the slice-width constant (2).
REQ-031 One sub-module cmp2_slice SHALL implement the purely combinational 2-bit gt/eq/lt compare and be instantiated exactly once.
REQ-032 No bidirectional or unused ports; index register width = clog2(WIDTH/2), minimum 1.

Verification
REQ-033 WIDTH=8, a=0xC0, b=0x40, start one cycle -> done in cycle 2, gt=1, eq=0, lt=0, busy high in cycle 1 only.
REQ-034 WIDTH=8, a=0x5A, b=0x5A -> busy cycles 1-4, done in cycle 5, eq=1.
REQ-035 WIDTH=8, a=0x12, b=0x13 -> done in cycle 5, lt=1; a, b driven to 0xFF, 0x00 during cycles 1-4 leave result unchanged.
REQ-036 start pulsed in cycles 2 and 3 during a busy comparison -> ignored; exactly one done pulse; result matches the first operands.
REQ-037 rst asserted in cycle 2 of an equal-operand comparison -> outputs zero immediately, no done pulse; a fresh start afterwards completes correctly.
REQ-038 start held high for 20 cycles with random operands -> result matches a reference compare on every done pulse; one IDLE cycle between consecutive comparisons.

Source files
------------

// File: rtl/cmp_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cmp_seq_pkg
// Description : Shared definitions for the sequential magnitude comparator:
//               FSM state encoding, slice width and index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cmp_seq_pkg;

  // Number of operand bits examined per clock by the comparator slice.
  localparam int c_SLICE_W = 2;

  // Controller states; 2-bit encoding, value 2'd3 is unreachable.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of the slice index register: clog2(number of slices), never below 1
  // so a single-slice operand still gets a legal vector.
  function automatic int idx_width(input int width);
    int n_slices;
    n_slices = width / c_SLICE_W;
    return (n_slices > 1) ? $clog2(n_slices) : 1;
  endfunction

endpackage : cmp_seq_pkg
`default_nettype wire

// File: rtl/cmp2_slice.sv
`default_nettype none
// ============================================================================
// Module      : cmp2_slice
// Description : Purely combinational unsigned compare of one 2-bit slice.
//               Exactly one of gt/eq/lt is high for any input.
// Revision    : 1.0 - initial release
// ============================================================================
module cmp2_slice
  import cmp_seq_pkg::*;
(
  input  logic [c_SLICE_W-1:0] a_slice,
  input  logic [c_SLICE_W-1:0] b_slice,
  output logic                 gt,
  output logic                 eq,
  output logic                 lt
);

  // Three-way decode of the slice relation.
  always_comb begin
    gt = 1'b0;
    eq = 1'b0;
    lt = 1'b0;
    if (a_slice > b_slice) begin
      gt = 1'b1;
    end else if (a_slice < b_slice) begin
      lt = 1'b1;
    end else begin
      eq = 1'b1;
    end
  end

endmodule : cmp2_slice
`default_nettype wire

// File: rtl/mag_cmp_seq.sv
`default_nettype none
// ============================================================================
// Module      : mag_cmp_seq
// Description : Sequential unsigned magnitude comparator. Walks the latched
//               operands one 2-bit slice per clock from the MSB end and stops
//               at the first differing slice. Registered gt/eq/lt results,
//               busy while comparing, one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mag_cmp_seq
  import cmp_seq_pkg::*;
#(
  // Operand width; must be even and at least 2.
  parameter int WIDTH = 8
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int               c_NSLICE  = WIDTH / c_SLICE_W;
  localparam int               c_IDX_W   = idx_width(WIDTH);
  localparam logic [c_IDX_W-1:0] c_IDX_TOP = c_IDX_W'(c_NSLICE - 1);

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [c_IDX_W-1:0]   r_idx;
  logic                 r_gt;
  logic                 r_eq;
  logic                 r_lt;

  logic                 w_load;
  logic                 w_last;
  logic [WIDTH-1:0]     w_a_sh;
  logic [WIDTH-1:0]     w_b_sh;
  logic [c_SLICE_W-1:0] w_a_sl;
  logic [c_SLICE_W-1:0] w_b_sl;
  logic                 w_sl_gt;
  logic                 w_sl_eq;
  logic                 w_sl_lt;

  // Select the indexed slice of the latched operands by shifting it to bit 0.
  always_comb begin
    w_a_sh = r_a >> (r_idx * c_SLICE_W);
    w_b_sh = r_b >> (r_idx * c_SLICE_W);
    w_a_sl = w_a_sh[c_SLICE_W-1:0];
    w_b_sl = w_b_sh[c_SLICE_W-1:0];
  end

  // The single comparator slice, time-shared across all operand slices.
  cmp2_slice u_slice (
    .a_slice (w_a_sl),
    .b_slice (w_b_sl),
    .gt      (w_sl_gt),
    .eq      (w_sl_eq),
    .lt      (w_sl_lt)
  );

  assign w_last = (r_idx == '0);

  // State register; reset aborts any comparison in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and state decodes for busy/done/operand load.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = CMP;
        end
      end
      CMP: begin
        busy = 1'b1;
        // Any differing slice decides the result; equal slices continue
        // until the LSB slice has been examined.
        if (!w_sl_eq || w_last) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Operand capture, slice index walk and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_idx <= '0;
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
    end else if (w_load) begin
      // Operands are frozen here so later changes on a/b cannot leak in.
      r_a   <= a;
      r_b   <= b;
      r_idx <= c_IDX_TOP;
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
    end else if (r_state == CMP) begin
      if (w_sl_gt) begin
        r_gt <= 1'b1;
      end else if (w_sl_lt) begin
        r_lt <= 1'b1;
      end else if (w_last) begin
        r_eq <= 1'b1;
      end else begin
        r_idx <= r_idx - 1'b1;
      end
    end
  end

  assign gt = r_gt;
  assign eq = r_eq;
  assign lt = r_lt;

endmodule : mag_cmp_seq
`default_nettype wire
